// File: rtl/vga_time_overlay.sv
// Overlays an HH:MM:SS seven-segment readout on the pic_RGB stream, with a 2-p_tick
// pipeline, frame-synchronous digit reload and frame-counted colon blinking.
module vga_time_overlay #(
    parameter int          X0           = 192,
    parameter int          Y0           = 208,
    parameter logic [7:0]  FG           = 8'hFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [7:0]  pic_RGB,
    input  logic [23:0] time_bcd,
    input  logic        time_valid,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [7:0]  RGB_out,
    output logic        frame_tick
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Segment boxes, index 0..6 = a,b,c,d,e,f,g (concatenations list g first).
    localparam logic [34:0] SEG_XL = {5'd4,  5'd4, 5'd4, 5'd4,  5'd22, 5'd22, 5'd4};
    localparam logic [34:0] SEG_XH = {5'd27, 5'd9, 5'd9, 5'd27, 5'd27, 5'd27, 5'd27};
    localparam logic [41:0] SEG_YL = {6'd29, 6'd4,  6'd29, 6'd54, 6'd29, 6'd4,  6'd4};
    localparam logic [41:0] SEG_YH = {6'd34, 6'd34, 6'd59, 6'd59, 6'd59, 6'd34, 6'd9};

    logic [23:0]   shadow_reg;
    logic [23:0]   display_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          colon_on_reg;

    logic          video_on1_reg;
    logic          hsync1_reg;
    logic          vsync1_reg;
    logic [7:0]    rgb1_reg;
    logic          in_win1_reg;
    logic [2:0]    cell1_reg;
    logic [4:0]    lx1_reg;
    logic [5:0]    ly1_reg;

    logic          boundary;
    logic          in_win_next;
    logic [7:0]    dx;
    logic [5:0]    dy;
    logic [3:0]    digit;
    logic          is_colon;
    logic [6:0]    seg_mask;
    logic [6:0]    seg_in;
    logic          colon_hit;
    logic          glyph_hit;
    logic [7:0]    rgb_next;

    assign boundary = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd480);

    // Only the low bits of the offsets are consumed; they equal the low bits of the
    // full 10-bit difference, and in_win gates any use so x<X0 cannot alias in.
    assign dx = pixel_x[7:0] - 8'(X0);
    assign dy = pixel_y[5:0] - 6'(Y0);
    assign in_win_next = (pixel_x >= 10'(X0)) && ({1'b0, pixel_x} < 11'(X0 + 256)) &&
                         (pixel_y >= 10'(Y0)) && ({1'b0, pixel_y} < 11'(Y0 + 64));

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg <= '0;
        end else if (time_valid) begin
            shadow_reg <= time_bcd;
        end
    end

    // Display reload and blink phase both advance on the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_reg   <= '0;
            blink_cnt_reg <= '0;
            colon_on_reg  <= 1'b1;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (boundary) begin
                display_reg <= shadow_reg;
                if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_reg <= '0;
                    colon_on_reg  <= ~colon_on_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            video_on1_reg <= 1'b0;
            hsync1_reg    <= 1'b0;
            vsync1_reg    <= 1'b0;
            rgb1_reg      <= '0;
            in_win1_reg   <= 1'b0;
            cell1_reg     <= '0;
            lx1_reg       <= '0;
            ly1_reg       <= '0;
        end else if (p_tick) begin
            video_on1_reg <= video_on;
            hsync1_reg    <= hsync_in;
            vsync1_reg    <= vsync_in;
            rgb1_reg      <= pic_RGB;
            in_win1_reg   <= in_win_next;
            cell1_reg     <= dx[7:5];
            lx1_reg       <= dx[4:0];
            ly1_reg       <= dy;
        end
    end

    always_comb begin
        digit    = 4'hF;
        is_colon = 1'b0;
        case (cell1_reg)
            3'd0:    digit = display_reg[23:20];
            3'd1:    digit = display_reg[19:16];
            3'd3:    digit = display_reg[15:12];
            3'd4:    digit = display_reg[11:8];
            3'd6:    digit = display_reg[7:4];
            3'd7:    digit = display_reg[3:0];
            default: is_colon = 1'b1;
        endcase
    end

    // Bit order {g,f,e,d,c,b,a}; non-BCD nibbles leave the cell blank.
    always_comb begin
        seg_mask = 7'b0000000;
        case (digit)
            4'd0: seg_mask = 7'b0111111;
            4'd1: seg_mask = 7'b0000110;
            4'd2: seg_mask = 7'b1011011;
            4'd3: seg_mask = 7'b1001111;
            4'd4: seg_mask = 7'b1100110;
            4'd5: seg_mask = 7'b1101101;
            4'd6: seg_mask = 7'b1111101;
            4'd7: seg_mask = 7'b0000111;
            4'd8: seg_mask = 7'b1111111;
            4'd9: seg_mask = 7'b1101111;
            default: seg_mask = 7'b0000000;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_seg
            assign seg_in[gi] = (lx1_reg >= SEG_XL[gi*5 +: 5]) && (lx1_reg <= SEG_XH[gi*5 +: 5]) &&
                                (ly1_reg >= SEG_YL[gi*6 +: 6]) && (ly1_reg <= SEG_YH[gi*6 +: 6]);
        end
    endgenerate

    assign colon_hit = colon_on_reg && (lx1_reg >= 5'd13) && (lx1_reg <= 5'd18) &&
                       (((ly1_reg >= 6'd18) && (ly1_reg <= 6'd23)) ||
                        ((ly1_reg >= 6'd40) && (ly1_reg <= 6'd45)));
    assign glyph_hit = is_colon ? colon_hit : |(seg_mask & seg_in);

    always_comb begin
        rgb_next = rgb1_reg;
        if (!video_on1_reg) begin
            rgb_next = 8'h00;
        end else if (in_win1_reg && glyph_hit) begin
            rgb_next = FG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            RGB_out   <= '0;
        end else if (p_tick) begin
            hsync_out <= hsync1_reg;
            vsync_out <= vsync1_reg;
            RGB_out   <= rgb_next;
        end
    end

endmodule
